control_seq: RTL and testbench

Registered, parametrised successor to the combinational main decoder. Decodes opcode/funct from the ID stage into a control bundle and captures it in the ID/EX control register. Adds stall/flush handling, halfword memory access, link/branch-sense outputs, illegal-opcode reporting, and a multi-cycle MULT/DIV sequencer that interlocks HI/LO consumers. Sits between the ID stage and the ID/EX pipeline register in the 5-stage core.

---
 rtl/control_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_control_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// ID-stage control decoder with registered ID/EX control bundle and a MULT/DIV busy sequencer.
// Define CONTROL_MULDIV_EN to build the MULT/DIV/MFHI/MFLO support and the HI/LO interlock.
module control_seq #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter logic [4:0]  LINK_REG   = 5'd31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       stall,
    input  logic       flush,
    output logic       id_stall,
    output logic       out_valid,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       memread,
    output logic       memwrite,
    output logic       isbranch,
    output logic       branchne,
    output logic       regdst,
    output logic       aluop,
    output logic       alusrc,
    output logic       isjump,
    output logic       islink,
    output logic       jumpdst,
    output logic [1:0] memtype,
    output logic [4:0] linkreg,
    output logic       illegal,
    output logic       muldiv_busy
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21, OP_LW   = 6'h23, OP_SB   = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18, FN_DIV  = 6'h1A;

    if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_bad_lat
        $error("MULDIV_LAT must be in 1..15");
    end

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       isbranch;
        logic       branchne;
        logic       regdst;
        logic       aluop;
        logic       alusrc;
        logic       isjump;
        logic       islink;
        logic       jumpdst;
        logic [1:0] memtype;
        logic [4:0] linkreg;
        logic       illegal;
    } ctrl_t;

    ctrl_t ctrl_q, ctrl_d, dec;
    logic  dec_known, op_muldiv, op_hilo, accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dec       = '0;
        dec_known = 1'b1;
        op_muldiv = 1'b0;
        op_hilo   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    dec.isjump  = 1'b1;
                    dec.jumpdst = 1'b1;
                end else if (funct == FN_MULT || funct == FN_DIV) begin
                    op_muldiv = 1'b1;
                end else if (funct == FN_MFHI || funct == FN_MFLO) begin
                    op_hilo = 1'b1;
                end else if (funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                           [6'h20:6'h27], 6'h2A, 6'h2B}) begin
                    dec.regwrite = 1'b1;
                    dec.regdst   = 1'b1;
                end else begin
                    dec_known = 1'b0;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 1'b1;
            end
            OP_LB, OP_LH, OP_LW: begin
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 1'b1;
                dec.memtype  = (opcode == OP_LB) ? 2'b00 : (opcode == OP_LH) ? 2'b01 : 2'b10;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 1'b1;
                dec.memtype  = (opcode == OP_SB) ? 2'b00 : (opcode == OP_SH) ? 2'b01 : 2'b10;
            end
            OP_BEQ, OP_BNE: begin
                dec.isbranch = 1'b1;
                dec.branchne = (opcode == OP_BNE);
                dec.aluop    = 1'b1;
            end
            OP_J: begin
                dec.isjump = 1'b1;
                dec.aluop  = 1'b1;
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.isjump   = 1'b1;
                dec.islink   = 1'b1;
                dec.aluop    = 1'b1;
                dec.linkreg  = LINK_REG;
            end
            default: dec_known = 1'b0;
        endcase
`ifdef CONTROL_MULDIV_EN
        // MULT/DIV write only HI/LO, so the bundle stays all-zero apart from valid.
        if (op_hilo) begin
            dec.regwrite = 1'b1;
            dec.regdst   = 1'b1;
        end
`else
        if (op_muldiv || op_hilo) dec_known = 1'b0;
`endif
    end

    assign accept = in_valid & ~stall & ~id_stall & ~flush;

    always_comb begin
        ctrl_d = '0;
        if (flush) begin
            ctrl_d = '0;
        end else if (stall) begin
            ctrl_d         = ctrl_q;
            ctrl_d.illegal = 1'b0;
        end else if (accept) begin
            if (dec_known) begin
                ctrl_d       = dec;
                ctrl_d.valid = 1'b1;
            end else begin
                ctrl_d.illegal = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ctrl_q <= '0;
        else       ctrl_q <= ctrl_d;
    end

`ifdef CONTROL_MULDIV_EN
    typedef enum logic {S_IDLE, S_BUSY} seq_state_t;

    seq_state_t state_q, state_d;
    logic [3:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (accept && op_muldiv) begin
                    state_d = S_BUSY;
                    count_d = 4'(MULDIV_LAT);
                end
            end
            S_BUSY: begin
                // Counts down regardless of stall/flush; an in-flight MULT/DIV is never cancelled.
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign muldiv_busy = (state_q == S_BUSY);
    assign id_stall    = in_valid & muldiv_busy & (op_muldiv | op_hilo);
`else
    assign muldiv_busy = 1'b0;
    assign id_stall    = 1'b0;
`endif

    assign out_valid = ctrl_q.valid;
    assign regwrite  = ctrl_q.regwrite;
    assign memtoreg  = ctrl_q.memtoreg;
    assign memread   = ctrl_q.memread;
    assign memwrite  = ctrl_q.memwrite;
    assign isbranch  = ctrl_q.isbranch;
    assign branchne  = ctrl_q.branchne;
    assign regdst    = ctrl_q.regdst;
    assign aluop     = ctrl_q.aluop;
    assign alusrc    = ctrl_q.alusrc;
    assign isjump    = ctrl_q.isjump;
    assign islink    = ctrl_q.islink;
    assign jumpdst   = ctrl_q.jumpdst;
    assign memtype   = ctrl_q.memtype;
    assign linkreg   = ctrl_q.linkreg;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: directed scenarios plus random traffic against a reference model.
module tb_control_seq;

    localparam int         LAT  = 4;
    localparam logic [4:0] LREG = 5'd31;
`ifdef CONTROL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic       out_valid;
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       isbranch;
        logic       branchne;
        logic       regdst;
        logic       aluop;
        logic       alusrc;
        logic       isjump;
        logic       islink;
        logic       jumpdst;
        logic [1:0] memtype;
        logic [4:0] linkreg;
        logic       illegal;
    } bundle_t;

    logic       clk, reset, in_valid, stall, flush;
    logic [5:0] opcode, funct;
    logic       id_stall, out_valid, regwrite, memtoreg, memread, memwrite, isbranch, branchne;
    logic       regdst, aluop, alusrc, isjump, islink, jumpdst, illegal, muldiv_busy;
    logic [1:0] memtype;
    logic [4:0] linkreg;

    control_seq #(.MULDIV_LAT(LAT), .LINK_REG(LREG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct(funct),
        .stall(stall), .flush(flush), .id_stall(id_stall), .out_valid(out_valid),
        .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
        .isbranch(isbranch), .branchne(branchne), .regdst(regdst), .aluop(aluop),
        .alusrc(alusrc), .isjump(isjump), .islink(islink), .jumpdst(jumpdst),
        .memtype(memtype), .linkreg(linkreg), .illegal(illegal), .muldiv_busy(muldiv_busy)
    );

    bundle_t act;
    assign act = {out_valid, regwrite, memtoreg, memread, memwrite, isbranch, branchne, regdst,
                  aluop, alusrc, isjump, islink, jumpdst, memtype, linkreg, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      vectors    = 0;
    int      miscompares = 0;
    bundle_t exp_q      = '0;
    int      cyc        = 0;
    int      acc_edge   = -1000;
    int      stall_seen = 0;

    // The unit is busy for the LAT cycles following the edge that accepted MULT/DIV.
    function automatic bit model_busy();
        return MD_EN && (cyc >= acc_edge) && (cyc < acc_edge + LAT);
    endfunction

    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       output bundle_t b, output bit known,
                                       output bit is_md, output bit interlocked);
        bit rt, r_alu, jr, mdv, hilo, itype, ld, st, beq, bne, j, jal;
        rt    = (op == 6'h00);
        jr    = rt && fn == 6'h08;
        mdv   = rt && fn inside {6'h18, 6'h1A};
        hilo  = rt && fn inside {6'h10, 6'h12};
        r_alu = rt && fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        itype = op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        ld    = op inside {6'h20, 6'h21, 6'h23};
        st    = op inside {6'h28, 6'h29, 6'h2B};
        beq   = (op == 6'h04);
        bne   = (op == 6'h05);
        j     = (op == 6'h02);
        jal   = (op == 6'h03);
        known = r_alu | jr | itype | ld | st | beq | bne | j | jal | (MD_EN & (mdv | hilo));
        is_md = MD_EN & mdv;
        interlocked = MD_EN & (mdv | hilo);
        b = '0;
        b.regwrite = r_alu | itype | ld | jal | (MD_EN & hilo);
        b.regdst   = r_alu | (MD_EN & hilo);
        b.memtoreg = ld;
        b.memread  = ld;
        b.memwrite = st;
        b.alusrc   = itype | ld | st;
        b.aluop    = itype | ld | st | beq | bne | j | jal;
        b.isbranch = beq | bne;
        b.branchne = bne;
        b.isjump   = jr | j | jal;
        b.jumpdst  = jr;
        b.islink   = jal;
        b.linkreg  = jal ? LREG : 5'd0;
        if (ld | st) b.memtype = (op[2:0] == 3'b000) ? 2'd0 : (op[2:0] == 3'b001) ? 2'd1 : 2'd2;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_bundle(input string tag);
        vectors++;
        assert (act === exp_q) else begin
            miscompares++;
            $error("FAIL %s: observed bundle %05h expected %05h", tag, act, exp_q);
        end
    endtask

    // One clock: apply inputs, check the combinational interlock, clock, check the register.
    task automatic cycle(input logic iv, input logic [5:0] op, input logic [5:0] fn,
                         input logic st, input logic fl, input string tag);
        bundle_t dec, nxt;
        bit known, is_md, inter, busy, stall_exp, acc;
        in_valid = iv; opcode = op; funct = fn; stall = st; flush = fl;
        #1;
        ref_decode(op, fn, dec, known, is_md, inter);
        busy      = model_busy();
        stall_exp = iv & busy & inter;
        acc       = iv & ~st & ~stall_exp & ~fl;
        if (id_stall === 1'b1) stall_seen++;
        check_val({tag, " id_stall"}, 32'(id_stall), 32'(stall_exp));
        check_val({tag, " muldiv_busy"}, 32'(muldiv_busy), 32'(busy));
        nxt = '0;
        if (fl) begin
            nxt = '0;
        end else if (st) begin
            nxt = exp_q;
            nxt.illegal = 1'b0;
        end else if (acc) begin
            if (known) begin
                nxt = dec;
                nxt.out_valid = 1'b1;
            end else begin
                nxt.illegal = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        if (acc && is_md) acc_edge = cyc;
        exp_q = nxt;
        #1;
        check_bundle(tag);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; opcode = '0; funct = '0;
        reset = 1'b1;
        #1;
        exp_q    = '0;
        acc_edge = -1000;
        check_bundle({tag, " immediate"});
        check_val({tag, " busy immediate"}, 32'(muldiv_busy), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        check_bundle({tag, " held"});
    endtask

    logic [5:0] op_tab [17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                                6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fn_tab [8]  = '{6'h18, 6'h1A, 6'h10, 6'h12, 6'h20, 6'h08, 6'h2A, 6'h00};

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; opcode = '0; funct = '0;
        #2;
        do_reset("reset");

        cycle(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, "lw");
        check_val("lw memtype", 32'(memtype), 32'd2);
        check_val("lw memread", 32'(memread), 32'd1);
        cycle(1'b1, 6'h29, 6'h00, 1'b0, 1'b0, "sh");
        check_val("sh memtype", 32'(memtype), 32'd1);
        check_val("sh memwrite", 32'(memwrite), 32'd1);
        cycle(1'b1, 6'h05, 6'h00, 1'b0, 1'b0, "bne");
        check_val("bne branchne", 32'({out_valid, isbranch, branchne}), 32'h7);

        cycle(1'b1, 6'h03, 6'h00, 1'b0, 1'b0, "jal");
        check_val("jal linkreg", 32'({islink, regwrite, linkreg}), 32'h7F);
        cycle(1'b0, 6'h03, 6'h00, 1'b0, 1'b0, "jal bubble");
        check_val("bubble linkreg", 32'(linkreg), 32'd0);

        cycle(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, "addi");
        cycle(1'b1, 6'h08, 6'h00, 1'b1, 1'b0, "addi stall1");
        check_val("stall holds addi", 32'({out_valid, alusrc}), 32'h3);
        cycle(1'b1, 6'h08, 6'h00, 1'b1, 1'b1, "addi stall+flush");
        cycle(1'b1, 6'h08, 6'h00, 1'b1, 1'b0, "addi stall3");
        check_val("flushed stays 0", 32'(out_valid), 32'd0);

        cycle(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, "op3f");
        check_val("op3f illegal", 32'({illegal, out_valid}), 32'h2);
        cycle(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, "after illegal");
        check_val("illegal pulse", 32'(illegal), 32'd0);

        cycle(1'b1, 6'h00, 6'h18, 1'b0, 1'b0, "mult");
        check_val("mult illegal", 32'(illegal), MD_EN ? 32'd0 : 32'd1);
        stall_seen = 0;
        for (int i = 0; i < LAT + 1; i++) cycle(1'b1, 6'h00, 6'h12, 1'b0, 1'b0, "mflo");
        check_val("mflo interlock cycles", 32'(stall_seen), MD_EN ? 32'(LAT) : 32'd0);

        cycle(1'b1, 6'h00, 6'h18, 1'b0, 1'b0, "mult2");
        cycle(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, "mult2 wait1");
        cycle(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, "mult2 wait2");
        @(negedge clk);
        do_reset("reset mid-mult");
        cycle(1'b1, 6'h00, 6'h10, 1'b0, 1'b0, "mfhi after reset");
        check_val("mfhi no stall", 32'(stall_seen), MD_EN ? 32'(LAT) : 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            int k;
            k  = int'($urandom_range(0, 18));
            op = (k < 17) ? op_tab[k] : 6'($urandom);
            k  = int'($urandom_range(0, 8));
            fn = (k < 8) ? fn_tab[k] : 6'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), op, fn,
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
